// File: rtl/mult_16x16.sv
// Unsigned 16x16 -> 32-bit multiplier: three-stage pipelined Wallace tree.
// Levels 1-3 -> reg -> levels 4-6 -> reg -> carry-propagate add -> reg.
module mult_16x16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [31:0] out,
  output logic        out_valid
);

  // Rows are kept pre-weighted at 32 bits, so a 3:2 compressor is a bitwise
  // full-adder per column with its carry vector moved up one column.
  function automatic logic [31:0] f_csa_sum(input logic [31:0] x,
                                            input logic [31:0] y,
                                            input logic [31:0] z);
    return x ^ y ^ z;
  endfunction

  function automatic logic [31:0] f_csa_carry(input logic [31:0] x,
                                              input logic [31:0] y,
                                              input logic [31:0] z);
    return ((x & y) | (x & z) | (y & z)) << 1;
  endfunction

  logic [31:0] w_pp [16];
  logic [31:0] w_l1 [11];
  logic [31:0] w_l2 [8];
  logic [31:0] w_l3 [6];

  logic [31:0] r_s1_row [6];
  logic        r_s1_valid;

  logic [31:0] w_l4 [4];
  logic [31:0] w_l5 [3];
  logic [31:0] w_l6_sum;
  logic [31:0] w_l6_carry;

  logic [31:0] r_s2_sum;
  logic [31:0] r_s2_carry;
  logic        r_s2_valid;

  // Partial products: row i is (a & b[i]) weighted by 2^i
  always_comb begin
    for (int unsigned i = 0; i < 16; i++) begin
      w_pp[i] = {16'h0000, a & {16{b[i]}}} << i;
    end
  end

  // Level 1: 16 -> 11 rows
  always_comb begin
    for (int unsigned g = 0; g < 5; g++) begin
      w_l1[2*g]   = f_csa_sum  (w_pp[3*g], w_pp[3*g+1], w_pp[3*g+2]);
      w_l1[2*g+1] = f_csa_carry(w_pp[3*g], w_pp[3*g+1], w_pp[3*g+2]);
    end
    w_l1[10] = w_pp[15];
  end

  // Level 2: 11 -> 8 rows
  always_comb begin
    for (int unsigned g = 0; g < 3; g++) begin
      w_l2[2*g]   = f_csa_sum  (w_l1[3*g], w_l1[3*g+1], w_l1[3*g+2]);
      w_l2[2*g+1] = f_csa_carry(w_l1[3*g], w_l1[3*g+1], w_l1[3*g+2]);
    end
    w_l2[6] = w_l1[9];
    w_l2[7] = w_l1[10];
  end

  // Level 3: 8 -> 6 rows
  always_comb begin
    for (int unsigned g = 0; g < 2; g++) begin
      w_l3[2*g]   = f_csa_sum  (w_l2[3*g], w_l2[3*g+1], w_l2[3*g+2]);
      w_l3[2*g+1] = f_csa_carry(w_l2[3*g], w_l2[3*g+1], w_l2[3*g+2]);
    end
    w_l3[4] = w_l2[6];
    w_l3[5] = w_l2[7];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 6; i++) begin
        r_s1_row[i] <= '0;
      end
      r_s1_valid <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < 6; i++) begin
        r_s1_row[i] <= w_l3[i];
      end
      r_s1_valid <= in_valid;
    end
  end

  // Level 4: 6 -> 4 rows
  always_comb begin
    for (int unsigned g = 0; g < 2; g++) begin
      w_l4[2*g]   = f_csa_sum  (r_s1_row[3*g], r_s1_row[3*g+1], r_s1_row[3*g+2]);
      w_l4[2*g+1] = f_csa_carry(r_s1_row[3*g], r_s1_row[3*g+1], r_s1_row[3*g+2]);
    end
  end

  // Level 5: 4 -> 3 rows
  always_comb begin
    w_l5[0] = f_csa_sum  (w_l4[0], w_l4[1], w_l4[2]);
    w_l5[1] = f_csa_carry(w_l4[0], w_l4[1], w_l4[2]);
    w_l5[2] = w_l4[3];
  end

  // Level 6: 3 -> 2 rows (bits shifted past column 31 are always zero)
  always_comb begin
    w_l6_sum   = f_csa_sum  (w_l5[0], w_l5[1], w_l5[2]);
    w_l6_carry = f_csa_carry(w_l5[0], w_l5[1], w_l5[2]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s2_sum   <= '0;
      r_s2_carry <= '0;
      r_s2_valid <= 1'b0;
    end else begin
      r_s2_sum   <= w_l6_sum;
      r_s2_carry <= w_l6_carry;
      r_s2_valid <= r_s1_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      out       <= r_s2_sum + r_s2_carry;
      out_valid <= r_s2_valid;
    end
  end

endmodule

// File: tb/tb_mult_16x16.sv
// Self-checking bench for mult_16x16: queue scoreboard of expected products,
// popped three edges after the operands are sampled.
module tb_mult_16x16;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] a;
  logic [15:0] b;
  logic [31:0] out;
  logic        out_valid;

  int unsigned n_checks;
  int unsigned n_pass;

  // {valid, product}, one entry per non-reset edge
  logic [32:0] sb [$];

  mult_16x16 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .out       (out),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
  endtask

  // Drive one cycle, let the edge happen, then check what the DUT shows.
  task automatic step(input string tag, input logic r, input logic v,
                      input logic [15:0] x, input logic [15:0] y,
                      input logic [31:0] expd);
    logic [32:0] e;
    rst_n    = r;
    in_valid = v;
    a        = x;
    b        = y;
    @(posedge clk);
    #1;
    if (!r) begin
      sb.delete();
      check({tag, "_rst_out"}, out, 32'h0);
      check({tag, "_rst_vld"}, {31'b0, out_valid}, 32'h0);
    end else begin
      sb.push_back({v, expd});
      if (sb.size() == 3) begin
        e = sb.pop_front();
        check({tag, "_vld"}, {31'b0, out_valid}, {31'b0, e[32]});
        if (e[32]) check({tag, "_out"}, out, e[31:0]);
      end else begin
        check({tag, "_fill_vld"}, {31'b0, out_valid}, 32'h0);
      end
    end
  endtask

  task automatic mul(input string tag, input logic [15:0] x, input logic [15:0] y);
    step(tag, 1'b1, 1'b1, x, y, {16'h0, x} * {16'h0, y});
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step("idle", 1'b1, 1'b0, 16'h0, 16'h0, 32'h0);
  endtask

  logic [15:0] dir_a [9];
  logic [15:0] dir_b [9];
  logic [31:0] dir_p [9];
  logic [15:0] corner [5];

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;

    dir_a = '{16'h0000, 16'h0001, 16'h0003, 16'h00FF, 16'h0F0F, 16'h1234, 16'h8000, 16'h7FFF, 16'hFFFF};
    dir_b = '{16'h0000, 16'h0001, 16'h0004, 16'h000F, 16'h00F0, 16'h5678, 16'h0002, 16'h7FFF, 16'hFFFF};
    dir_p = '{32'h00000000, 32'h00000001, 32'h0000000C, 32'h00000EF1, 32'h000E1E10,
              32'h06260060, 32'h00010000, 32'h3FFF0001, 32'hFFFE0001};
    corner = '{16'h0000, 16'hFFFF, 16'h8000, 16'hAAAA, 16'h5555};

    // Reset held with random operands, then idle after release
    for (int i = 0; i < 2; i++)
      step("reset", 1'b0, 1'($urandom), 16'($urandom), 16'($urandom), 32'h0);
    idle(3);

    for (int i = 0; i < 9; i++) step("dir", 1'b1, 1'b1, dir_a[i], dir_b[i], dir_p[i]);
    idle(3);

    // Bubble: valid, gap, valid
    step("bub", 1'b1, 1'b1, 16'h0003, 16'h0004, 32'h0000000C);
    step("bub", 1'b1, 1'b0, 16'h1111, 16'h2222, 32'h0);
    step("bub", 1'b1, 1'b1, 16'hFFFF, 16'h0001, 32'h0000FFFF);
    idle(3);

    // Mid-stream reset flushes the two in-flight products
    mul("mid", 16'h1234, 16'h4321);
    mul("mid", 16'hBEEF, 16'hCAFE);
    step("mid", 1'b0, 1'b1, 16'hDEAD, 16'hF00D, 32'h0);
    mul("mid", 16'h00AB, 16'h00CD);
    idle(3);

    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++) mul("corner", corner[i], corner[j]);

    for (int i = 0; i < 10000; i++) mul("rnd", 16'($urandom), 16'($urandom));
    idle(3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
